dcache_wb: RTL

Write-back engine for the data cache. On eviction of a dirty line it reads the line out of the cache data RAM through that RAM's combinational read port (port b), holds it in a private line buffer, and sends it to memory as one AXI INCR write burst. The cache controller can refill the evicted slot as soon as the capture phase ends. It sits between the dcache controller, the four byte-lane data RAMs (read port), and the AXI write channels of the bus bridge.

---
 rtl/dcache_wb_pkg.sv | 20 ++
 rtl/dcache_wb_if.sv | 41 ++++
 rtl/dcache_wb_buf.sv | 22 ++
 rtl/dcache_wb.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/dcache_wb_pkg.sv
// dcache_wb_pkg: shared definitions for the data-cache write-back engine.
//   wb_state_e      - engine FSM encoding
//   AXI_SIZE_4B     - AWSIZE for 32-bit beats
//   AXI_BURST_INCR  - AWBURST for incrementing bursts
//   WB_AXI_ID       - AXI ID used on AW and W
//   WSTRB_FULL      - all four byte lanes enabled
package dcache_wb_pkg;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_ADDR    = 3'd2,
    S_DATA    = 3'd3,
    S_RESP    = 3'd4
  } wb_state_e;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] WB_AXI_ID      = 4'd1;
  localparam logic [3:0] WSTRB_FULL     = 4'hf;
endpackage

// File: rtl/dcache_wb_if.sv
// dcache_wb_if: AXI write-channel bundle (AW, W, B) between the write-back
// engine and the bus bridge.
//   master - the write-back engine (drives AW/W, bready)
//   slave  - the bus bridge (drives awready, wready, B channel)
interface dcache_wb_if;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/dcache_wb_buf.sv
// dcache_wb_buf: LINE_WORDS x 32 register line buffer.
//   clk          - clock
//   we/waddr/wdata - single write port
//   raddr/rdata  - combinational read port
// No reset: contents are always written before they are read.
module dcache_wb_buf #(
  parameter int LINE_WORDS = 8
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [$clog2(LINE_WORDS)-1:0] waddr,
  input  logic [31:0]                   wdata,
  input  logic [$clog2(LINE_WORDS)-1:0] raddr,
  output logic [31:0]                   rdata
);
  logic [LINE_WORDS-1:0][31:0] mem;

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/dcache_wb.sv
// dcache_wb: data-cache write-back engine. Copies a dirty line out of the
// data RAM read port into a private buffer, then sends it as one AXI INCR
// write burst.
//   clk, rst        - clock, synchronous active-high reset
//   wb_req/wb_ready - write-back request handshake (wb_index, wb_addr)
//   wb_captured     - pulse: line copied, RAM slot may be refilled
//   wb_done         - pulse: write response received
//   wb_busy         - engine not idle
//   ram_raddr/ram_rdata - data RAM combinational read port
//   axi             - AXI AW/W/B channels (master side)
// Build option: DCACHE_WB_AW_W_OVERLAP_EN lets W beats start alongside AW.
module dcache_wb
  import dcache_wb_pkg::*;
#(
  parameter int LINE_WORDS = 8,
  parameter int RAM_AW     = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 wb_req,
  output logic                                 wb_ready,
  input  logic [RAM_AW-$clog2(LINE_WORDS)-1:0] wb_index,
  input  logic [31:0]                          wb_addr,
  output logic                                 wb_captured,
  output logic                                 wb_done,
  output logic                                 wb_busy,
  output logic [RAM_AW-1:0]                    ram_raddr,
  input  logic [31:0]                          ram_rdata,
  dcache_wb_if.master                          axi
);
  localparam int CW  = $clog2(LINE_WORDS);
  localparam int OFF = CW + 2;
  localparam int IW  = RAM_AW - CW;
  localparam logic [CW-1:0] LAST = CW'(LINE_WORDS - 1);

  wb_state_e   state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [31:0] awaddr_q;
  logic [31:0] buf_rdata;
  logic        w_hs;
`ifdef DCACHE_WB_AW_W_OVERLAP_EN
  logic        w_ok;  // last W beat already accepted while still in ADDR
`endif

  // Line offset bits of wb_addr and the B channel ID/response carry no
  // information for this engine.
  logic unused_ok;
  assign unused_ok = ^{axi.bid, axi.bresp, wb_addr[OFF-1:0]};

  dcache_wb_buf #(.LINE_WORDS(LINE_WORDS)) u_buf (
    .clk   (clk),
    .we    (state == S_CAPTURE),
    .waddr (cnt),
    .wdata (ram_rdata),
    .raddr (cnt),
    .rdata (buf_rdata)
  );

  assign wb_ready  = (state == S_IDLE);
  assign wb_busy   = (state != S_IDLE);
  assign ram_raddr = (state == S_CAPTURE) ? {idx, cnt} : '0;

  assign axi.awid    = WB_AXI_ID;
  assign axi.awaddr  = awaddr_q;
  assign axi.awlen   = 8'(LINE_WORDS - 1);
  assign axi.awsize  = AXI_SIZE_4B;
  assign axi.awburst = AXI_BURST_INCR;
  assign axi.awvalid = (state == S_ADDR);
  assign axi.wid     = WB_AXI_ID;
  assign axi.wstrb   = WSTRB_FULL;
`ifdef DCACHE_WB_AW_W_OVERLAP_EN
  assign axi.wvalid  = (state == S_DATA) || ((state == S_ADDR) && !w_ok);
`else
  assign axi.wvalid  = (state == S_DATA);
`endif
  assign axi.wdata   = axi.wvalid ? buf_rdata : '0;
  assign axi.wlast   = axi.wvalid && (cnt == LAST);
  assign axi.bready  = (state == S_RESP);
  assign w_hs        = axi.wvalid && axi.wready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      idx         <= '0;
      awaddr_q    <= '0;
      wb_captured <= 1'b0;
      wb_done     <= 1'b0;
`ifdef DCACHE_WB_AW_W_OVERLAP_EN
      w_ok        <= 1'b0;
`endif
    end else begin
      wb_captured <= 1'b0;
      wb_done     <= 1'b0;
      case (state)
        S_IDLE: if (wb_req) begin
          idx      <= wb_index;
          awaddr_q <= {wb_addr[31:OFF], {OFF{1'b0}}};
          cnt      <= '0;
          state    <= S_CAPTURE;
        end
        // cnt wraps to 0 on the last capture cycle, ready for beat 0.
        S_CAPTURE: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state       <= S_ADDR;
            wb_captured <= 1'b1;
`ifdef DCACHE_WB_AW_W_OVERLAP_EN
            w_ok        <= 1'b0;
`endif
          end
        end
        S_ADDR: begin
`ifdef DCACHE_WB_AW_W_OVERLAP_EN
          if (w_hs) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) w_ok <= 1'b1;
          end
          // RESP needs both the AW and the last W handshake, in either order.
          if (axi.awready)
            state <= (w_ok || (w_hs && cnt == LAST)) ? S_RESP : S_DATA;
`else
          if (axi.awready) begin
            cnt   <= '0;
            state <= S_DATA;
          end
`endif
        end
        S_DATA: if (w_hs) begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= S_RESP;
        end
        S_RESP: if (axi.bvalid) begin
          state   <= S_IDLE;
          wb_done <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
